// File: rtl/vending_balance_tracker_pkg.sv
// Shared definitions for the vending machine balance ledger.
// Holds the machine dimensions, the coin value and item price tables,
// the widened arithmetic type and the ledger state encoding.
package vending_balance_tracker_pkg;

   localparam int kNumCoins   = 3;
   localparam int kNumItems   = 4;
   localparam int kTotalBits  = 31;
   localparam int kMaxBalance = 10000;

   // One extra bit so subtraction and credit can be checked before truncation.
   typedef logic [kTotalBits:0] wide_t;

   localparam wide_t kCoinValue [kNumCoins] = '{wide_t'(100), wide_t'(500), wide_t'(1000)};
   localparam wide_t kItemPrice [kNumItems] = '{wide_t'(400), wide_t'(500), wide_t'(1000), wide_t'(2000)};

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_RETURN = 1'b1
   } state_t;

endpackage

// File: rtl/vending_coin_sum.sv
// Combinational sum of coin values selected by a coin mask.
// Ports:
//   coin_mask   - one bit per denomination, any combination may be set
//   coin_total  - sum of the selected coin values (widened)
module vending_coin_sum
   import vending_balance_tracker_pkg::*;
(
   input  logic [kNumCoins-1:0] coin_mask,
   output wide_t                coin_total
);

   always_comb begin
      coin_total = '0;
      for (int i = 0; i < kNumCoins; i++) begin
         if (coin_mask[i]) coin_total = coin_total + kCoinValue[i];
      end
   end

endmodule

// File: rtl/vending_balance_tracker.sv
// Balance ledger for the vending machine. Sole owner of the balance register:
// credits inserted coins, debits accepted item prices and coins ejected by the
// return-timer stage, and reports item availability from the registered balance.
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   i_input_coin      - coin-inserted pulses
//   i_select_item     - item-request pulses (lowest index wins)
//   i_trigger_return  - user return request
//   i_return_coin     - coin ejected this cycle by the return-timer stage
//   o_relative_money  - registered balance
//   o_available_item  - bit i set when balance covers price i
//   o_output_item     - one-cycle dispense pulse
//   o_coin_reject     - one-cycle pulse when inserted coins are refused
//   o_returning       - high while in RETURN
//
// state     | meaning
// ST_IDLE   | normal trading: coins credited, selections served
// ST_RETURN | paying out: coins refused, selections ignored, exit when balance is 0
module vending_balance_tracker
   import vending_balance_tracker_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [kNumCoins-1:0]  i_input_coin,
   input  logic [kNumItems-1:0]  i_select_item,
   input  logic                  i_trigger_return,
   input  logic [kNumCoins-1:0]  i_return_coin,
   output logic [kTotalBits-1:0] o_relative_money,
   output logic [kNumItems-1:0]  o_available_item,
   output logic [kNumItems-1:0]  o_output_item,
   output logic                  o_coin_reject,
   output logic                  o_returning
);

   state_t                 state_q, state_d;
   logic [kTotalBits-1:0]  balance_q, balance_d;
   logic [kNumItems-1:0]   output_item_q, output_item_d;
   logic                   coin_reject_q, coin_reject_d;

   wide_t                  bal_w;
   wide_t                  insert_sum;
   wide_t                  return_sum;
   wide_t                  price;
   wide_t                  after_price;
   wide_t                  after_return;
   wide_t                  credit;
   wide_t                  total;
   logic                   sel_found;

   assign bal_w = {1'b0, balance_q};

   vending_coin_sum u_insert_sum (
      .coin_mask  (i_input_coin),
      .coin_total (insert_sum)
   );

   vending_coin_sum u_return_sum (
      .coin_mask  (i_return_coin),
      .coin_total (return_sum)
   );

   always_comb begin
      state_d       = state_q;
      output_item_d = '0;
      coin_reject_d = 1'b0;
      price         = '0;
      credit        = '0;
      sel_found     = 1'b0;

      // Only the lowest requested item is considered, funded by the pre-coin balance.
      if (state_q == ST_IDLE) begin
         for (int i = 0; i < kNumItems; i++) begin
            if (i_select_item[i] && !sel_found) begin
               sel_found = 1'b1;
               if (kItemPrice[i] <= bal_w) begin
                  price            = kItemPrice[i];
                  output_item_d[i] = 1'b1;
               end
            end
         end
      end

      after_price = bal_w - price;

      // The timer may eject the smallest coin when less than it remains.
      after_return = (after_price >= return_sum) ? (after_price - return_sum) : '0;

      if (i_input_coin != '0) begin
         if ((state_q == ST_IDLE) && ((after_price + insert_sum) <= wide_t'(kMaxBalance)))
            credit = insert_sum;
         else
            coin_reject_d = 1'b1;
      end

      total = after_return + credit;
      if (total > wide_t'(kMaxBalance)) total = wide_t'(kMaxBalance);
      balance_d = total[kTotalBits-1:0];

      case (state_q)
         ST_IDLE:   if (i_trigger_return) state_d = ST_RETURN;
         ST_RETURN: if (bal_w == '0)      state_d = ST_IDLE;
         default:                         state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         balance_q     <= '0;
         output_item_q <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         balance_q     <= balance_d;
         output_item_q <= output_item_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   always_comb begin
      o_available_item = '0;
      for (int i = 0; i < kNumItems; i++) begin
         o_available_item[i] = (bal_w >= kItemPrice[i]);
      end
   end

   assign o_relative_money = balance_q;
   assign o_output_item    = output_item_q;
   assign o_coin_reject    = coin_reject_q;
   assign o_returning      = (state_q == ST_RETURN);

endmodule
